core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_if.sv | 36 +++
 rtl/core_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_core_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_if.sv
// Host/core-facing bundle for core_ctrl: job request, host data beats, ofifo status, core instruction and status.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready handshake on host beats; ofifo_valid gates result draining.
//
// Ports (slave = controller side):
//   start, len          job request and activation-vector count
//   in_data, in_valid   host beat (activations, then weights); in_ready returned
//   ofifo_valid         core output FIFO holds a result row
//   inst, D_xmem        core instruction word and xMem write data
//   busy, done          job status; cycle_cnt busy-cycle counter
interface core_ctrl_if #(
    parameter int row = 8,
    parameter int bw  = 4
);
    logic                start;
    logic [9:0]          len;
    logic [bw*row-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic                ofifo_valid;
    logic [33:0]         inst;
    logic [bw*row-1:0]   D_xmem;
    logic                busy;
    logic                done;
    logic [31:0]         cycle_cnt;

    modport slave (
        input  start, len, in_data, in_valid, ofifo_valid,
        output in_ready, inst, D_xmem, busy, done, cycle_cnt
    );

    modport master (
        output start, len, in_data, in_valid, ofifo_valid,
        input  in_ready, inst, D_xmem, busy, done, cycle_cnt
    );
endinterface

// File: rtl/core_ctrl.sv
// Job sequencer for the PE core: loads activations/weights into xMem, feeds L0, runs the array, drains results to psum.
// Latency: all outputs registered; start -> first in_ready is 1 cycle, each instruction appears the cycle after its decision.
// Backpressure: host beats only move on in_valid&in_ready; DRAIN stalls indefinitely while ofifo_valid is low.
//
// Ports: clk, reset (synchronous, active-high), bus (core_ctrl_if.slave: start/len, in_data/in_valid/in_ready,
//        ofifo_valid, inst, D_xmem, busy, done, cycle_cnt).
// Optional feature: define CORE_CTRL_CYCLE_CNT_EN to build the busy-cycle counter; otherwise cycle_cnt is tied to 0.
module core_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int bw     = 4,
    parameter int W_BASE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    core_ctrl_if.slave  bus
);
    localparam int DW = bw * row;

    // CEN/WEN of both SRAMs high, everything else low.
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    localparam logic [10:0] ROW_A   = 11'(row);
    localparam logic [10:0] LOADLEN = 11'(row + col);
    localparam logic [10:0] WB      = 11'(W_BASE);

    typedef enum logic [3:0] {
        IDLE, WR_X, WR_W, RD_W, KLOAD, RD_X, EXEC, DRAIN, DONE
    } state_t;

    state_t          state;
    logic [10:0]     cnt;
    logic [9:0]      lenQ;
    logic [33:0]     instQ;
    logic [DW-1:0]   dXmemQ;
    logic            inReadyQ;
    logic            busyQ;
    logic            doneQ;
    logic            l0WrPend;   // a read went out last cycle; its data lands in L0 now
    logic            psumPend;   // an ofifo row was popped last cycle; write it to psum now
    logic [10:0]     psumAddr;

    logic [10:0]     lenW;
    logic [10:0]     execLen;
    logic [10:0]     rdLast;

    assign lenW    = {1'b0, lenQ};
    assign execLen = lenW + LOADLEN;
    assign rdLast  = (state == RD_W) ? ROW_A : lenW;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lenQ     <= '0;
            instQ    <= IDLE_WORD;
            dXmemQ   <= '0;
            inReadyQ <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            l0WrPend <= 1'b0;
            psumPend <= 1'b0;
            psumAddr <= '0;
        end else begin
            // Each cycle starts from the idle word; states override the fields they drive.
            instQ    <= IDLE_WORD;
            instQ[2] <= l0WrPend;
            l0WrPend <= 1'b0;
            doneQ    <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lenQ  <= bus.len;
                        cnt   <= '0;
                        busyQ <= 1'b1;
                        if (bus.len != 10'd0) begin
                            state    <= WR_X;
                            inReadyQ <= 1'b1;
                        end else begin
                            state <= DONE;
                            doneQ <= 1'b1;
                        end
                    end
                end

                WR_X, WR_W: begin
                    if (bus.in_valid && inReadyQ) begin
                        instQ[19]   <= 1'b0;
                        instQ[18]   <= 1'b0;
                        instQ[17:7] <= (state == WR_W) ? (WB + cnt) : cnt;
                        dXmemQ      <= bus.in_data;
                        if (state == WR_X && cnt == lenW - 11'd1) begin
                            state <= WR_W;
                            cnt   <= '0;
                        end else if (state == WR_W && cnt == ROW_A - 11'd1) begin
                            state    <= RD_W;
                            cnt      <= '0;
                            inReadyQ <= 1'b0;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end

                // Reads occupy cnt 0..rdLast-1; the extra cycle at cnt==rdLast lets the
                // trailing l0_wr of the last read go out before the next phase starts.
                RD_W, RD_X: begin
                    if (cnt < rdLast) begin
                        instQ[19]   <= 1'b0;
                        instQ[17:7] <= (state == RD_W) ? (WB + cnt) : cnt;
                        l0WrPend    <= 1'b1;
                        cnt         <= cnt + 11'd1;
                    end else begin
                        state <= (state == RD_W) ? KLOAD : EXEC;
                        cnt   <= '0;
                    end
                end

                KLOAD: begin
                    instQ[0] <= 1'b1;
                    instQ[3] <= 1'b1;
                    if (cnt == LOADLEN - 11'd1) begin
                        state <= RD_X;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                EXEC: begin
                    instQ[1] <= 1'b1;
                    instQ[3] <= 1'b1;
                    if (cnt == execLen - 11'd1) begin
                        state    <= DRAIN;
                        cnt      <= '0;
                        psumPend <= 1'b0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end

                // cnt counts popped rows; the psum write for a row follows its pop by one
                // cycle, so the job only finishes once no write is still pending.
                DRAIN: begin
                    psumPend <= 1'b0;
                    if (psumPend) begin
                        instQ[32]    <= 1'b0;
                        instQ[31]    <= 1'b0;
                        instQ[30:20] <= psumAddr;
                    end
                    if (bus.ofifo_valid && cnt < lenW) begin
                        instQ[6] <= 1'b1;
                        psumPend <= 1'b1;
                        psumAddr <= cnt;
                        cnt      <= cnt + 11'd1;
                    end else if (cnt == lenW && !psumPend) begin
                        state <= DONE;
                        cnt   <= '0;
                        doneQ <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busyQ <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    busyQ    <= 1'b0;
                    inReadyQ <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst     = instQ;
    assign bus.D_xmem   = dXmemQ;
    assign bus.in_ready = inReadyQ;
    assign bus.busy     = busyQ;
    assign bus.done     = doneQ;

`ifdef CORE_CTRL_CYCLE_CNT_EN
    logic [31:0] cycleCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCnt <= '0;
        end else if (state == IDLE && bus.start) begin
            cycleCnt <= '0;
        end else if (busyQ) begin
            cycleCnt <= cycleCnt + 32'd1;
        end
    end

    assign bus.cycle_cnt = cycleCnt;
`else
    assign bus.cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: reset state, full jobs with steady and toggling host beats,
// a DRAIN stall, start ignored mid-job, zero-length job and reset during EXEC.
module tb_core_ctrl;
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    core_ctrl_if #(.row(8), .bw(4)) bus();

    core_ctrl #(.row(8), .col(8), .bw(4), .W_BASE(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k);
        return 32'hC0DE_0000 + 32'(k * 37);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runJob(input int n, input bit toggle, input bit stall);
        int  wrN = 0, rdN = 0, l0wN = 0, ldN = 0, l0rN = 0, exN = 0;
        int  ofrN = 0, psN = 0, dnN = 0, busyN = 0, stallLeft = 0, beat = 0;
        bit  prevXfer = 1'b0, prevEx = 1'b0, doneSeen = 1'b0, finished = 1'b0;
        int  expA;
        bus.len         = 10'(n);
        bus.start       = 1'b1;
        bus.ofifo_valid = !stall;
        bus.in_valid    = 1'b1;
        bus.in_data     = pat(0);
        tick();
        bus.start = 1'b0;
        chk("start_to_in_ready", bus.in_ready, 1);
        for (int c = 0; c < 600 && !finished; c++) begin
            if (doneSeen) begin
                chk("busy_after_done", bus.busy, 0);
                chk("done_single_pulse", bus.done, 0);
`ifdef CORE_CTRL_CYCLE_CNT_EN
                chk("cycle_cnt", bus.cycle_cnt, busyN);
`else
                chk("cycle_cnt_off", bus.cycle_cnt, 0);
`endif
                finished = 1'b1;
            end else begin
                if (bus.busy) busyN++;
                chk("inst_zero_bits", {bus.inst[33], bus.inst[5], bus.inst[4]}, 0);
                if (!bus.inst[19]) begin
                    if (!bus.inst[18]) begin
                        expA = (wrN < n) ? wrN : 1024 + wrN - n;
                        chk("xmem_wr_addr", bus.inst[17:7], expA);
                        chk("xmem_wr_data", bus.D_xmem, pat(wrN));
                        chk("xmem_wr_on_xfer", prevXfer, 1);
                        wrN++;
                    end else begin
                        expA = (rdN < 8) ? 1024 + rdN : rdN - 8;
                        chk("xmem_rd_addr", bus.inst[17:7], expA);
                        rdN++;
                    end
                end
                if (!bus.inst[32]) begin
                    chk("psum_wen", bus.inst[31], 0);
                    chk("psum_addr", bus.inst[30:20], psN);
                    psN++;
                end
                l0wN += int'(bus.inst[2]);
                ldN  += int'(bus.inst[0]);
                l0rN += int'(bus.inst[3]);
                exN  += int'(bus.inst[1]);
                ofrN += int'(bus.inst[6]);
                if (stall && prevEx && !bus.inst[1]) stallLeft = 10;
                if (stallLeft > 0) begin
                    chk("stall_no_ofifo_rd", bus.inst[6], 0);
                    chk("stall_no_psum_wr", bus.inst[32], 1);
                    chk("stall_busy", bus.busy, 1);
                    stallLeft--;
                    if (stallLeft == 0) bus.ofifo_valid = 1'b1;
                end
                if (bus.done) begin
                    dnN++;
                    doneSeen = 1'b1;
                    chk("busy_with_done", bus.busy, 1);
                end
                prevEx       = bus.inst[1];
                bus.in_valid = toggle ? !bus.in_valid : 1'b1;
                bus.in_data  = pat(beat);
                prevXfer     = bus.in_valid && bus.in_ready;
                if (prevXfer) beat++;
                bus.start    = (c == 30);
                tick();
            end
        end
        bus.start = 1'b0;
        if (!finished) chk("job_timeout", 0, 1);
        chk("xmem_writes", wrN, n + 8);
        chk("xmem_reads", rdN, n + 8);
        chk("l0_wr_count", l0wN, n + 8);
        chk("kload_cycles", ldN, 16);
        chk("exec_cycles", exN, n + 16);
        chk("l0_rd_count", l0rN, n + 32);
        chk("ofifo_rd_count", ofrN, n);
        chk("psum_writes", psN, n);
        chk("done_count", dnN, 1);
    endtask

    initial begin
        bit sawExec;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.len         = '0;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.ofifo_valid = 1'b0;
        repeat (3) tick();
        chk("rst_inst", bus.inst, IDLE_WORD);
        chk("rst_dxmem", bus.D_xmem, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cycle_cnt", bus.cycle_cnt, 0);
        reset = 1'b0;
        tick();
        chk("idle_inst", bus.inst, IDLE_WORD);

        // Steady beats, ofifo always ready, a stray start mid-job.
        runJob(4, 1'b0, 1'b0);
        tick();
        // Beats on every other cycle, DRAIN held off for 10 cycles.
        runJob(4, 1'b1, 1'b1);
        tick();

        // Zero-length job: done the cycle after start, no SRAM access.
        bus.len   = 10'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("len0_done", bus.done, 1);
        chk("len0_busy", bus.busy, 1);
        chk("len0_inst", bus.inst, IDLE_WORD);
        tick();
        chk("len0_done_fall", bus.done, 0);
        chk("len0_busy_fall", bus.busy, 0);
        chk("len0_inst_after", bus.inst, IDLE_WORD);
`ifdef CORE_CTRL_CYCLE_CNT_EN
        chk("len0_cycle_cnt", bus.cycle_cnt, 1);
`else
        chk("len0_cycle_cnt_off", bus.cycle_cnt, 0);
`endif

        // Reset while executing.
        bus.len         = 10'd4;
        bus.start       = 1'b1;
        bus.in_valid    = 1'b1;
        bus.ofifo_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        sawExec   = 1'b0;
        for (int c = 0; c < 200 && !sawExec; c++) begin
            if (bus.inst[1]) sawExec = 1'b1;
            else tick();
        end
        chk("reach_exec", sawExec, 1);
        reset = 1'b1;
        tick();
        chk("rst_exec_inst", bus.inst, IDLE_WORD);
        chk("rst_exec_busy", bus.busy, 0);
        chk("rst_exec_in_ready", bus.in_ready, 0);
        chk("rst_exec_done", bus.done, 0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("post_rst_idle", bus.inst, IDLE_WORD);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
